mux_2_1_arb: RTL

- Two-input round-robin stream arbiter with bounded bursts; sits directly upstream of mux_2_1 in the datapath.
- Accepts two valid/ready byte streams (a, b) and issues one registered output stream.
- Drives sel_o with mux_2_1's select convention: 0 = a, 1 = b. sel_o can feed mux_2_1 sel_i or be used as a source tag downstream.

---
 rtl/mux_2_1_arb_if.sv | 26 ++
 rtl/mux_2_1_arb.sv | 106 ++++++++++
 2 files changed

// File: rtl/mux_2_1_arb_if.sv
// Valid/ready bundle between two byte sources, the arbiter and one downstream sink.
// Handshake: a beat moves on a rising edge where valid && ready; valid never waits on ready.
interface mux_2_1_arb_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_i;
  logic             a_valid_i;
  logic             a_ready_o;
  logic [WIDTH-1:0] b_i;
  logic             b_valid_i;
  logic             b_ready_o;
  logic [WIDTH-1:0] y_o;
  logic             y_valid_o;
  logic             y_ready_i;
  logic             sel_o;

  modport slave (
    input  a_i, a_valid_i, b_i, b_valid_i, y_ready_i,
    output a_ready_o, b_ready_o, y_o, y_valid_o, sel_o
  );

  modport master (
    output a_i, a_valid_i, b_i, b_valid_i, y_ready_i,
    input  a_ready_o, b_ready_o, y_o, y_valid_o, sel_o
  );
endinterface

// File: rtl/mux_2_1_arb.sv
// Two-source round-robin stream arbiter with bounded bursts and a registered output beat.
// sel_o follows the mux_2_1 select convention: 0 = a, 1 = b.
module mux_2_1_arb #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mux_2_1_arb_if.slave        bus,
  output logic [1:0]          state_o
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST_A = 2'd1,
    BURST_B = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_b_q, last_b_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              y_valid_q, y_valid_d;
  logic              sel_q, sel_d;
  logic              out_free;
  logic              gnt_a, gnt_b;
  logic              same_burst;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_b_d   = last_b_q;
    y_d        = y_q;
    y_valid_d  = y_valid_q;
    sel_d      = sel_q;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    same_burst = 1'b0;
    out_free   = !y_valid_q || bus.y_ready_i;

    // Readies are gated by reset so nothing is consumed while the block is held.
    if (rst_ni && out_free) begin
      if (bus.a_valid_i && !bus.b_valid_i) begin
        gnt_a = 1'b1;
      end else if (bus.b_valid_i && !bus.a_valid_i) begin
        gnt_b = 1'b1;
      end else if (bus.a_valid_i && bus.b_valid_i) begin
        if (state_q == BURST_A && cnt_q < MAX_CNT) begin
          gnt_a = 1'b1;
        end else if (state_q == BURST_B && cnt_q < MAX_CNT) begin
          gnt_b = 1'b1;
        end else begin
          gnt_a = last_b_q;
          gnt_b = !last_b_q;
        end
      end

      if (gnt_a || gnt_b) begin
        y_valid_d  = 1'b1;
        y_d        = gnt_b ? bus.b_i : bus.a_i;
        sel_d      = gnt_b;
        same_burst = (gnt_a && state_q == BURST_A) || (gnt_b && state_q == BURST_B);
        if (same_burst) begin
          cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CW'(1);
        end else begin
          cnt_d    = CW'(1);
          state_d  = gnt_b ? BURST_B : BURST_A;
          last_b_d = gnt_b;
        end
      end else begin
        y_valid_d = 1'b0;
        state_d   = IDLE;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sel_q     <= sel_d;
    end
  end

  assign bus.a_ready_o = gnt_a;
  assign bus.b_ready_o = gnt_b;
  assign bus.y_o       = y_q;
  assign bus.y_valid_o = y_valid_q;
  assign bus.sel_o     = sel_q;
  assign state_o       = state_q;

endmodule
